sie_bus_master: RTL and testbench
=================================

Name: sie_bus_master

Overview:
- Initiator for the SIE 8-bit asynchronous SRAM-style bus (13-bit address, ncs/nwe/noe, bidirectional 8-bit data), i.e. the CPU side of the FPGA register/BRAM peripheral.
- Accepts byte or 32-bit word requests on a valid/ready interface and generates correctly timed byte bus cycles with programmable setup, strobe and hold.
- Used in-fabric as a bus exerciser and as the bench-side driver for peripheral verification.

Parameters:
- SETUP, 2, cycles of address valid with strobes high before strobe (min 1)
- STROBE, 4, cycles of ncs plus nwe or noe low (min 3; covers peripheral negedge-sync plus registered read)
- HOLD, 2, cycles of address/data held with strobes high after strobe (min 1)

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  master idle, can accept
- req_write  in  1  1=write, 0=read
- req_size  in  1  0=byte, 1=word (4 bytes)
- req_addr  in  13  byte address; word requests use req_addr[1:0]=0
- req_wdata  in  32  write data; byte uses [7:0]
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  32  read data
- busy  out  1  transaction in progress
- addr  out  13  bus address
- sram_data  inout  8  bus data
- ncs  out  1  chip select, active low
- nwe  out  1  write strobe, active low
- noe  out  1  output enable, active low

Behaviour:
- Reset (async, any time, including mid-transaction): ncs=nwe=noe=1, sram_data=Z, addr=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, state=IDLE; the in-flight request is dropped with no response.
- Accept occurs when req_valid and req_ready are both high at a rising edge. The master latches write, size, addr and wdata, sets byte index k=0, and drops req_ready.
- States: IDLE -> SETUP -> STROBE -> HOLD -> (next byte: SETUP | last byte: DONE) -> IDLE. A single down-counter loaded with SETUP-1, STROBE-1 or HOLD-1 sequences the phases.
- SETUP: addr = base+k; ncs=nwe=noe=1.
- STROBE: ncs=0. For writes nwe=0, noe=1; for reads noe=0, nwe=1.
- HOLD: strobes high; addr unchanged.
- Write data: sram_data drives byte k throughout SETUP, STROBE and HOLD of a write. It is Z in every other state and for all reads.
- Byte order is little-endian and ascending: byte k = wdata[8k+7:8k] at base+k, for k = 0..3. Byte 3 is issued last; the peripheral commits its 32-bit word on byte 3.
- Read sampling: sram_data is captured into rsp_rdata[8k+7:8k] at the rising edge that ends the final STROBE cycle. Byte reads zero rsp_rdata[31:8].
- DONE: rsp_valid=1 for exactly one cycle, then IDLE with req_ready=1. rsp_rdata is held stable until the next accept. Write responses leave rsp_rdata unchanged.
- Latency: rsp_valid is first high N*(SETUP+STROBE+HOLD)+1 cycles after the accept edge, where N=1 for byte and N=4 for word. With defaults: byte 9, word 33.
- Per-byte cycle time is 8 cycles with defaults. Between bytes of a word, strobes stay high for HOLD+SETUP cycles, which guarantees the peripheral sees a deasserted gap.
- busy = ~req_ready. req_valid is ignored while busy.
- Misaligned word (req_addr[1:0]≠0): req_addr[1:0] is forced to 0; no error signalled.
- Address wrap: base+k computed modulo 2^13 (0x1FFF+1 -> 0x0000).
- Outputs ncs, nwe, noe, addr and data-enable are registered; there is no combinational path from req_* to bus pins.

Optional Feature:
- Macro SIE_BUS_WAIT_EN adds input nwait (1 bit, active low, synchronized through 2 flops inside the block).
- With macro: once the STROBE count expires, STROBE is extended while synchronized nwait=0. Read sampling moves to the edge ending the last extended cycle. A 16-bit watchdog counter aborts after 65535 extension cycles: it goes to HOLD and then DONE, and asserts output rsp_err (1 bit) with rsp_valid. Read data for the aborted byte is 0xFF.
- Without macro: no nwait or rsp_err ports; STROBE is exactly STROBE cycles.

Test Plan:
- Byte write addr=0x1010, data=0xA5, defaults -> one ncs/nwe low pulse of 4 cycles; addr=0x1010 and sram_data=0xA5 stable from SETUP through HOLD; rsp_valid pulses 9 cycles after accept.
- Word write addr=0x0008, data=0x76543210 -> four cycles on 0x0008..0x000B with data 0x10, 0x32, 0x54, 0x76 in that order; strobe gap ≥4 cycles between bytes; rsp_valid at 33 cycles.
- Word read addr=0x0000 with a bus model returning 0x10, 0x32, 0x54, 0x76 -> rsp_rdata=0x76543210; nwe stays 1 and sram_data stays Z throughout.
- Byte read addr=0x1FFF returning 0xCE, then word read addr=0x1FFC -> rsp_rdata=0x000000CE for the byte read; the word read addresses 0x1FFC..0x1FFF with no wrap; req_valid held high during busy causes no second accept.
- nreset asserted during the STROBE of byte 2 of a word write -> ncs=nwe=1 and sram_data=Z asynchronously; no rsp_valid; a new byte read afterwards completes normally.
- SIE_BUS_WAIT_EN: nwait held low for 10 cycles after strobe expiry -> strobe lasts 14 cycles and rsp_valid arrives at 19 cycles; nwait held low permanently -> rsp_err=1 with rsp_valid, rsp_rdata[7:0]=0xFF.

Source files
------------

// File: rtl/sie_bus_master_if.sv
// sie_bus_master_if: request/response and SRAM control signals of the SIE bus master.
// SIE_BUS_WAIT_EN adds nwait and rsp_err.
interface sie_bus_master_if;
  logic        req_valid, req_ready, req_write, req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [12:0] addr;
  logic        ncs, nwe, noe;
`ifdef SIE_BUS_WAIT_EN
  logic nwait, rsp_err;
  modport master (input req_valid, req_write, req_size, req_addr, req_wdata, nwait,
                  output req_ready, rsp_valid, rsp_rdata, busy, addr, ncs, nwe, noe, rsp_err);
  modport slave (output req_valid, req_write, req_size, req_addr, req_wdata, nwait,
                 input req_ready, rsp_valid, rsp_rdata, busy, addr, ncs, nwe, noe, rsp_err);
`else
  modport master (input req_valid, req_write, req_size, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, busy, addr, ncs, nwe, noe);
  modport slave (output req_valid, req_write, req_size, req_addr, req_wdata,
                 input req_ready, rsp_valid, rsp_rdata, busy, addr, ncs, nwe, noe);
`endif
endinterface

// File: rtl/sie_bus_master.sv
// sie_bus_master: SIE 8-bit async SRAM bus initiator issuing byte/word requests as timed byte cycles.
// Define SIE_BUS_WAIT_EN to add nwait strobe extension with a 16-bit watchdog and rsp_err.
module sie_bus_master #(
  parameter int SETUP  = 2,
  parameter int STROBE = 4,
  parameter int HOLD   = 2
) (
  input  logic              clk,
  input  logic              nreset,
  sie_bus_master_if.master  bus,
  inout  wire  [7:0]        sram_data
);
  typedef enum logic [2:0] {S_IDLE, S_SET, S_STB, S_HLD, S_DONE} state_t;
  localparam logic [7:0] SET_N = 8'(SETUP - 1);
  localparam logic [7:0] STB_N = 8'(STROBE - 1);
  localparam logic [7:0] HLD_N = 8'(HOLD - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic        write_q, write_d, size_q, size_d;
  logic        rsp_valid_q, ncs_q, nwe_q, noe_q, oe_q;
  logic [12:0] base_q, base_d, addr_q;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  dout_q, rd_byte;
  logic        strobe_end, last_byte;
`ifdef SIE_BUS_WAIT_EN
  logic [1:0]  nw_q;
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d, rsp_err_q, stall;
  assign stall      = ~nw_q[1];
  assign strobe_end = ~stall || wd_q == 16'hFFFF;
  assign rd_byte    = stall ? 8'hFF : sram_data;
  assign last_byte  = ~size_q || k_q == 2'd3 || err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  assign strobe_end = 1'b1;
  assign rd_byte    = sram_data;
  assign last_byte  = ~size_q || k_q == 2'd3;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    k_d     = k_q;
    write_d = write_q;
    size_d  = size_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SIE_BUS_WAIT_EN
    wd_d  = wd_q;
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        state_d = S_SET;
        cnt_d   = SET_N;
        k_d     = '0;
        write_d = bus.req_write;
        size_d  = bus.req_size;
        base_d  = bus.req_size ? {bus.req_addr[12:2], 2'b00} : bus.req_addr;
        wdata_d = bus.req_wdata;
        rdata_d = bus.req_write ? rdata_q : '0;
`ifdef SIE_BUS_WAIT_EN
        err_d = 1'b0;
`endif
      end
      S_SET: if (cnt_q == '0) begin
        state_d = S_STB;
        cnt_d   = STB_N;
`ifdef SIE_BUS_WAIT_EN
        wd_d = '0;
`endif
      end
      S_STB: if (cnt_q == '0) begin
        if (strobe_end) begin
          state_d = S_HLD;
          cnt_d   = HLD_N;
          if (!write_q) rdata_d[{k_q, 3'b000} +: 8] = rd_byte;
`ifdef SIE_BUS_WAIT_EN
          err_d = stall;
`endif
        end else begin
          cnt_d = '0;
`ifdef SIE_BUS_WAIT_EN
          wd_d = wd_q + 16'd1;
`endif
        end
      end
      S_HLD: if (cnt_q == '0) begin
        state_d = last_byte ? S_DONE : S_SET;
        cnt_d   = SET_N;
        k_d     = k_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Bus pins are registered from next-state so no req_* path reaches them combinationally.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      write_q     <= 1'b0;
      size_q      <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      ncs_q       <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      write_q     <= write_d;
      size_q      <= size_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= state_q == S_DONE;
      addr_q      <= state_d == S_SET ? base_d + 13'(k_d) : addr_q;
      ncs_q       <= state_d != S_STB;
      nwe_q       <= !(state_d == S_STB && write_d);
      noe_q       <= !(state_d == S_STB && !write_d);
      oe_q        <= write_d && (state_d inside {S_SET, S_STB, S_HLD});
      dout_q      <= wdata_d[{k_d, 3'b000} +: 8];
    end
  end
`ifdef SIE_BUS_WAIT_EN
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      nw_q      <= 2'b11;
      wd_q      <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      nw_q      <= {nw_q[0], bus.nwait};
      wd_q      <= wd_d;
      err_q     <= err_d;
      rsp_err_q <= state_q == S_DONE && err_q;
    end
  end
`endif
  assign bus.req_ready = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.addr      = addr_q;
  assign bus.ncs       = ncs_q;
  assign bus.nwe       = nwe_q;
  assign bus.noe       = noe_q;
  assign sram_data     = oe_q ? dout_q : 8'hzz;
endmodule

// File: tb/tb_sie_bus_master.sv
// tb_sie_bus_master: random and directed requests against a byte-memory reference model;
// a negedge monitor checks bus cycles and responses popped from scoreboard queues.
module tb_sie_bus_master;
  localparam int SETUP = 2, STROBE = 4, HOLD = 2;
  localparam int CYC = SETUP + STROBE + HOLD;
  typedef struct { logic w; logic [31:0] rdata; int acc; int lat; } rsp_t;
  typedef struct { logic [12:0] a; logic w; logic [7:0] d; logic last; } byte_t;

  logic clk = 0, nreset = 1;
  always #5 clk = ~clk;
  sie_bus_master_if bus();
  wire [7:0] sram_data;
  sie_bus_master #(.SETUP(SETUP), .STROBE(STROBE), .HOLD(HOLD)) dut (
    .clk(clk), .nreset(nreset), .bus(bus), .sram_data(sram_data));

  rsp_t rq[$];
  byte_t bq[$];
  logic [7:0] ref_mem [8192];
  logic [7:0] bus_mem [8192];
  logic [7:0] rd_byte;
  logic [31:0] last_rd;
  bit bm_init;
  int n_cmp, n_err, cyc;

  function automatic logic [7:0] init_val(int i);
    logic [31:0] w = 32'h7654_3210;
    if (i < 4) return w[8*i +: 8];
    if (i == 'h1FFF) return 8'hCE;
    return 8'(i * 37) ^ 8'(i >> 5) ^ 8'h5A;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Peripheral model: returns memory bytes on reads, stores bytes on write strobes.
  assign rd_byte = bus_mem[bus.addr];
  assign sram_data = (!bus.ncs && !bus.noe) ? rd_byte : 8'hzz;
  always @(negedge clk) begin
    if (!bm_init) begin
      for (int i = 0; i < 8192; i++) bus_mem[i] <= init_val(i);
      bm_init <= 1;
    end else if (!bus.ncs && !bus.nwe) bus_mem[bus.addr] <= sram_data;
  end
  always @(posedge clk) cyc <= cyc + 1;

  bit in_p, more, rst_seen = 1, p_w, p_bad;
  int f_cyc, r_cyc;
  logic [12:0] p_a;
  logic [7:0] p_d;
  byte_t mb;
  rsp_t mr;
  always @(negedge clk) begin
    if (nreset) begin
      chk("rst_strobes", {bus.ncs, bus.nwe, bus.noe, bus.rsp_valid}, 4'b1110);
      rq.delete();
      bq.delete();
      in_p = 0;
      more = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
        chk("rst_addr", bus.addr, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        rst_seen = 0;
      end
      if (!bus.ncs) begin
        if (!in_p) begin
          in_p = 1;
          f_cyc = cyc;
          p_a = bus.addr;
          p_w = !bus.nwe;
          p_d = sram_data;
          p_bad = 0;
          if (more) chk("strobe_gap", cyc - r_cyc, HOLD + SETUP);
        end
        p_bad |= (bus.addr !== p_a) || (bus.nwe === bus.noe) || (!bus.nwe !== p_w) || (p_w && sram_data !== p_d);
      end else if (in_p) begin
        in_p = 0;
        r_cyc = cyc;
        if (bq.size() == 0) begin
          n_cmp++;
          n_err++;
          more = 0;
          $display("FAIL bus_extra: strobe at addr %h with none expected", p_a);
        end else begin
          mb = bq.pop_front();
          chk("bus_addr", p_a, mb.a);
          chk("bus_dir", p_w, mb.w);
          if (mb.w) chk("bus_wdata", p_d, mb.d);
          chk("strobe_len", cyc - f_cyc, STROBE);
          chk("strobe_stable", p_bad, 0);
          more = !mb.last;
        end
      end
      if (bus.rsp_valid) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_extra: rsp_valid with rdata %h, none expected", bus.rsp_rdata);
        end else begin
          mr = rq.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, mr.rdata);
          chk("rsp_latency", cyc - mr.acc, mr.lat);
          chk("rsp_idle", {bus.req_ready, bus.busy}, 2'b10);
        end
      end
    end
  end

  task automatic issue(logic w, logic sz, logic [12:0] a, logic [31:0] d, int hold, bit commit);
    int n = sz ? 4 : 1;
    int t = 0;
    logic [12:0] base = sz ? {a[12:2], 2'b00} : a;
    logic [31:0] rd = '0;
    byte_t b;
    rsp_t r;
    while (!bus.req_ready) begin
      @(posedge clk); #1;
      if (++t > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout: req_ready=%b expected 1", bus.req_ready);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "req_ready timeout");
      end
    end
    for (int k = 0; k < n; k++) begin
      b.a = 13'(base + 13'(k));
      b.w = w;
      b.d = d[8*k +: 8];
      b.last = (k == n - 1);
      bq.push_back(b);
      if (!w) rd[8*k +: 8] = ref_mem[b.a];
      else if (commit) ref_mem[b.a] = b.d;
    end
    if (!w) last_rd = rd;
    r.w = w;
    r.rdata = last_rd;
    r.lat = n * CYC + 1;
    r.acc = cyc + 1;
    rq.push_back(r);
    bus.req_write = w;
    bus.req_size = sz;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.req_valid = 0;
    bus.req_write = 1'($urandom);
    bus.req_size = 1'($urandom);
    bus.req_addr = 13'($urandom);
    bus.req_wdata = $urandom;
  endtask

  initial begin
    int t;
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_size = 0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
`ifdef SIE_BUS_WAIT_EN
    bus.nwait = 1;
`endif
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1 nreset = 0;
    @(posedge clk); #1;
    issue(1, 0, 13'h1010, 32'h0000_00A5, 0, 1);
    issue(1, 1, 13'h0008, 32'h7654_3210, 0, 1);
    issue(0, 1, 13'h0000, 32'h0, 0, 1);
    issue(0, 0, 13'h1FFF, 32'h0, 0, 1);
    issue(0, 1, 13'h1FFC, 32'h0, 3, 1);
    // Abort a word write during the strobe of byte 2; that write never reaches the model.
    issue(1, 1, 13'h0100, 32'hDEAD_BEEF, 0, 0);
    repeat (2 * CYC + SETUP) @(posedge clk);
    #2 nreset = 1;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #3 nreset = 0;
    @(posedge clk); #1;
    issue(0, 0, 13'h1010, 32'h0, 0, 1);
    issue(0, 1, 13'h000A, 32'h0, 1, 1);
    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 1'($urandom), 13'($urandom_range(13'h0200, 13'h1FFF)), $urandom,
            $urandom_range(0, 3), 1);
    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (rq.size() != 0 || bq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses and %0d bus bytes outstanding, expected 0", rq.size(), bq.size());
    end
    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
